// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Memory-side end of the MIPS load/store path. Accepts one request at a time,
//   waits LATENCY cycles to model memory latency, then performs the store or
//   returns load data with a one-cycle ready pulse. Word storage is internal.
//
// Parameters
//   DEPTH   : number of 32-bit words (4..1024)
//   LATENCY : cycles from request capture to response (1..15)
//
// Configuration macro
//   DMEM_BYTE_EN : when defined, byte/halfword accesses, sign/zero extension
//                  and misalignment errors are supported. When undefined,
//                  every access is a full-word access and only the range
//                  error remains.
//
// Ports
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset
//   req    in   request strobe, sampled only when a new request can be taken
//   we     in   1 = store, 0 = load
//   size   in   00 byte, 01 half, 10/11 word
//   sgn    in   load sign-extension select
//   addr   in   byte address
//   wd     in   store data (sub-word data in the low bits)
//   busy   out  request in flight
//   ready  out  one-cycle response pulse
//   err    out  request rejected (valid with ready)
//   rd     out  load data, held between loads
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        ready,
  output logic        err,
  output logic [31:0] rd
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic         r_we;
  logic [1:0]   r_size;
  logic         r_sgn;
  logic [31:0]  r_addr;
  logic [31:0]  r_wd;
  logic         r_busy;
  logic         r_ready;
  logic         r_err;
  logic [31:0]  r_rd;

  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_capture;
  logic          w_exec;
  logic          w_range_err;
  logic          w_align_err;
  logic          w_err;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_word;
  logic [31:0]   w_load;

  assign busy  = r_busy;
  assign ready = r_ready;
  assign err   = r_err;
  assign rd    = r_rd;

  assign w_idx       = r_addr[AW+1:2];
  assign w_range_err = (r_addr[31:2] >= 30'(DEPTH));
  assign w_err       = w_range_err | w_align_err;
  assign w_exec      = (r_state == S_WAIT) && (r_cnt == 4'd0);

  // A new request is taken in IDLE, or in RESP so that the request period is
  // LATENCY+1 cycles when req is held high.
  assign w_capture   = req && ((r_state == S_IDLE) || (r_state == S_RESP));

  // The registered read is issued one edge ahead of execution: on the capture
  // edge the index comes straight from the request, afterwards from r_addr.
  assign w_rd_idx    = w_capture ? addr[AW+1:2] : w_idx;

`ifdef DMEM_BYTE_EN
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_align_err = 1'b0;
    w_be        = 4'hF;
    w_wdata     = r_wd;
    case (r_size)
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wd[7:0]}};
      end
      2'b01: begin
        w_align_err = r_addr[0];
        w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata     = {2{r_wd[15:0]}};
      end
      default: begin
        w_align_err = (r_addr[1:0] != 2'b00);
      end
    endcase
  end

  assign w_shift = w_word >> {r_addr[1:0], 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = r_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    case (r_size)
      2'b00:   w_load = {{24{r_sgn & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_sgn & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end
`else
  // Word-only build: size, sgn and the low address bits have no effect.
  logic w_unused;
  assign w_unused    = ^{r_size, r_sgn, r_addr[1:0]};
  assign w_align_err = 1'b0;
  assign w_be        = 4'hF;
  assign w_wdata     = r_wd;
  assign w_load      = w_word;
`endif

  // One byte-wide memory per lane so each lane maps onto its own RAM with a
  // plain write enable. Contents are not reset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_q;

      always_ff @(posedge clk) begin
        if (w_exec && r_we && !w_err && w_be[gi]) begin
          r_mem[w_idx] <= w_wdata[8*gi +: 8];
        end
        r_q <= r_mem[w_rd_idx];
      end

      assign w_word[8*gi +: 8] = r_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_sgn   <= 1'b0;
      r_addr  <= 32'd0;
      r_wd    <= 32'd0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_RESP: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          if (w_capture) begin
            r_we    <= we;
            r_size  <= size;
            r_sgn   <= sgn;
            r_addr  <= addr;
            r_wd    <= wd;
            r_cnt   <= 4'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            r_err   <= w_err;
            if (!r_we && !w_err) begin
              r_rd <= w_load;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        req, we, sgn;
  logic [1:0]  size;
  logic [31:0] addr, wd;
  logic        busy, ready, err;
  logic [31:0] rd;

  // second instance with LATENCY=1 for the back-to-back request rate
  logic        req1;
  logic        busy1, ready1, err1;
  logic [31:0] rd1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          id;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_rd;
  int          req_id;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sgn(sgn),
    .addr(addr), .wd(wd), .busy(busy), .ready(ready), .err(err), .rd(rd)
  );

  dmem_responder #(.DEPTH(16), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(1'b1), .size(2'b10), .sgn(1'b0),
    .addr(32'd0), .wd(32'h0000_0000), .busy(busy1), .ready(ready1), .err(err1),
    .rd(rd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Scoreboard monitor: pops one expectation per ready pulse.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_ready: got ready=1 want no response");
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("req%0d err", e.id), {31'd0, err}, {31'd0, e.err});
        chk($sformatf("req%0d rd", e.id), rd, e.rd);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Issue one request; expected err and (for good loads) rd are hand-computed.
  task automatic do_req(input logic w, input logic [1:0] s, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_rd);
    exp_t e;
    int   lat;
    wait_idle();
    we = w; size = s; sgn = sg; addr = a; wd = d; req = 1'b1;
    if (!w && !e_err) model_rd = e_rd;
    e.err = e_err;
    e.rd  = model_rd;
    e.id  = req_id;
    sb_q.push_back(e);
    $display("req%0d: we=%0b size=%0d sgn=%0b addr=%h wd=%h exp_err=%0b exp_rd=%h",
             req_id, w, s, sg, a, d, e_err, model_rd);
    req_id++;
    @(negedge clk);
    chk("busy_after_capture", {31'd0, busy}, 32'd1);
    lat = 0;
    // scramble inputs (including req) while the request is in flight
    while (ready !== 1'b1 && lat < 40) begin
      req  = 1'($urandom);
      we   = 1'($urandom);
      size = 2'($urandom);
      sgn  = 1'($urandom);
      addr = $urandom;
      wd   = $urandom;
      @(negedge clk);
      lat++;
    end
    req = 1'b0;
    chk("latency", lat, LATENCY);
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sgn = 1'b0;
    addr = 32'd0; wd = 32'd0; req1 = 1'b0;
    model_rd = 32'd0; req_id = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy",  {31'd0, busy},  32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_err",   {31'd0, err},   32'd0);
    chk("reset_rd",    rd,             32'd0);
    reset = 1'b1;

    // back-to-back on the LATENCY=1 instance: ready after every even edge
    @(negedge clk);
    req1 = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      chk($sformatf("b2b_ready_edge%0d", n), {31'd0, ready1}, {31'd0, (n % 2 == 0)});
      if (ready1) chk("b2b_err", {31'd0, err1}, 32'd0);
    end
    req1 = 1'b0;
    @(negedge clk);
    chk("b2b_busy_end", {31'd0, busy1}, 32'd0);

    // basic word store/load
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEAD_BEEF);

`ifdef DMEM_BYTE_EN
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'hAAAA_AA80, 1'b0, 32'h0);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF80);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0000_0080);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h80AD_BEEF);
    do_req(1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 1'b1, 32'h0);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFF_80AD);
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_BEEF);
    do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF_1234, 1'b0, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h80AD_1234);
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 32'h0000_0012);
    do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h80AD_1234);
`else
    do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b0, 32'hDEAD_BEEF);
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h0123_4567, 1'b0, 32'h0);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h0123_4567);
`endif

    // range errors leave memory untouched
    do_req(1'b1, 2'b10, 1'b0, 32'h0,              32'hA5A5_A5A5, 1'b0, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, (DEPTH - 1) * 4,    32'h5A5A_5A5A, 1'b0, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, DEPTH * 4,          32'hFFFF_FFFF, 1'b1, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h8000_0000,      32'hFFFF_FFFF, 1'b1, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0,              32'h0, 1'b0, 32'hA5A5_A5A5);
    do_req(1'b0, 2'b10, 1'b0, (DEPTH - 1) * 4,    32'h0, 1'b0, 32'h5A5A_5A5A);
    do_req(1'b0, 2'b10, 1'b0, DEPTH * 4,          32'h0, 1'b1, 32'h0);

    // reset during WAIT aborts an in-flight store
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h1111_1111, 1'b0, 32'h0);
    wait_idle();
    we = 1'b1; size = 2'b10; sgn = 1'b0; addr = 32'h20; wd = 32'h2222_2222; req = 1'b1;
    $display("abort: store addr=00000020 wd=22222222 reset in WAIT");
    @(negedge clk);
    req = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("abort_busy",  {31'd0, busy},  32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd0);
    chk("abort_err",   {31'd0, err},   32'd0);
    chk("abort_rd",    rd,             32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_rd = 32'd0;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1111_1111);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
